// File: rtl/mdu_defs.sv
// Shared definitions for the EX-stage multiply/divide unit: op encodings,
// default latencies and the controller state type.
package mdu_defs;

    typedef enum logic [3:0] {
        MDU_NONE  = 4'd0,
        MDU_MULT  = 4'd1,
        MDU_MULTU = 4'd2,
        MDU_DIV   = 4'd3,
        MDU_DIVU  = 4'd4,
        MDU_MFHI  = 4'd5,
        MDU_MFLO  = 4'd6,
        MDU_MTHI  = 4'd7,
        MDU_MTLO  = 4'd8
    } mdu_op_e;

    localparam int MDU_MULT_CYCLES = 5;
    localparam int MDU_DIV_CYCLES  = 10;

    typedef enum logic {
        MDU_IDLE = 1'b0,
        MDU_RUN  = 1'b1
    } mdu_state_e;

endpackage

// File: rtl/mdu_unit.sv
// Multi-cycle MIPS multiply/divide unit owning HI/LO. The result is computed
// at the start edge and held in pending registers until the latency elapses.
module mdu_unit
    import mdu_defs::*;
#(
    parameter int MULT_CYCLES = MDU_MULT_CYCLES,
    parameter int DIV_CYCLES  = MDU_DIV_CYCLES
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        En,
    input  logic [3:0]  MduOp,
    input  logic [31:0] A,
    input  logic [31:0] B,
    output logic        Busy,
    output logic [31:0] HI,
    output logic [31:0] LO,
    output logic [31:0] Result
);

    mdu_state_e  state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [31:0] pend_hi_q, pend_hi_d;
    logic [31:0] pend_lo_q, pend_lo_d;
    logic        pend_wr_q, pend_wr_d;
    logic [31:0] hi_q, hi_d;
    logic [31:0] lo_q, lo_d;

    logic [63:0] prod_s, prod_u;
    logic [31:0] quot_s, rem_s, quot_u, rem_u;
    logic        idle_en;

    // Full-width products and quotients, evaluated from the live operands.
    always_comb begin
        prod_s = $signed({{32{A[31]}}, A}) * $signed({{32{B[31]}}, B});
        prod_u = {32'd0, A} * {32'd0, B};
        quot_s = '0;
        rem_s  = '0;
        quot_u = '0;
        rem_u  = '0;
        if (B != 32'd0) begin
            // Most-negative / -1 overflows; the architectural answer is fixed.
            if (A == 32'h8000_0000 && B == 32'hFFFF_FFFF) begin
                quot_s = 32'h8000_0000;
                rem_s  = 32'd0;
            end else begin
                quot_s = $signed(A) / $signed(B);
                rem_s  = $signed(A) % $signed(B);
            end
            quot_u = A / B;
            rem_u  = A % B;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= MDU_IDLE;
            cnt_q     <= '0;
            pend_hi_q <= '0;
            pend_lo_q <= '0;
            pend_wr_q <= 1'b0;
            hi_q      <= '0;
            lo_q      <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            pend_hi_q <= pend_hi_d;
            pend_lo_q <= pend_lo_d;
            pend_wr_q <= pend_wr_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
        end
    end

    assign idle_en = En && (state_q == MDU_IDLE);

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        pend_hi_d = pend_hi_q;
        pend_lo_d = pend_lo_q;
        pend_wr_d = pend_wr_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        if (state_q == MDU_IDLE) begin
            if (idle_en) begin
                case (MduOp)
                    MDU_MULT, MDU_MULTU: begin
                        state_d   = MDU_RUN;
                        cnt_d     = 4'(MULT_CYCLES);
                        pend_wr_d = 1'b1;
                        {pend_hi_d, pend_lo_d} = (MduOp == MDU_MULT) ? prod_s : prod_u;
                    end
                    MDU_DIV, MDU_DIVU: begin
                        state_d   = MDU_RUN;
                        cnt_d     = 4'(DIV_CYCLES);
                        pend_wr_d = (B != 32'd0);
                        pend_hi_d = (MduOp == MDU_DIV) ? rem_s  : rem_u;
                        pend_lo_d = (MduOp == MDU_DIV) ? quot_s : quot_u;
                    end
                    MDU_MTHI: hi_d = A;
                    MDU_MTLO: lo_d = A;
                    default: ;
                endcase
            end
        end else begin
            // Any En during RUN is a stall violation and is deliberately dropped.
            if (cnt_q == 4'd1) begin
                state_d = MDU_IDLE;
                cnt_d   = 4'd0;
                if (pend_wr_q) begin
                    hi_d = pend_hi_q;
                    lo_d = pend_lo_q;
                end
            end else begin
                cnt_d = cnt_q - 4'd1;
            end
        end
    end

    always_comb begin
        Busy = (state_q == MDU_RUN);
        HI   = hi_q;
        LO   = lo_q;
        case (MduOp)
            MDU_MFHI: Result = hi_q;
            MDU_MFLO: Result = lo_q;
            default:  Result = 32'd0;
        endcase
    end

endmodule

// File: tb/tb_mdu_unit.sv
// Self-checking bench for mdu_unit: directed cases plus randomized op streams
// compared against a plain-arithmetic HI/LO model.
module tb_mdu_unit;

    logic        clk;
    logic        rst_n;
    logic        En;
    logic [3:0]  MduOp;
    logic [31:0] A;
    logic [31:0] B;
    logic        Busy;
    logic [31:0] HI;
    logic [31:0] LO;
    logic [31:0] Result;

    int checks = 0;
    int errors = 0;

    logic [31:0] m_hi = 32'd0;
    logic [31:0] m_lo = 32'd0;

    mdu_unit dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .En     (En),
        .MduOp  (MduOp),
        .A      (A),
        .B      (B),
        .Busy   (Busy),
        .HI     (HI),
        .LO     (LO),
        .Result (Result)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Reference behaviour straight from the MIPS definitions, on 64-bit integers.
    task automatic model_apply(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        longint sa, sb, q, r;
        longint unsigned ua, ub, p;
        sa = longint'(int'(a));
        sb = longint'(int'(b));
        ua = longint'(a) & 64'h0000_0000_FFFF_FFFF;
        ub = longint'(b) & 64'h0000_0000_FFFF_FFFF;
        case (op)
            4'd1: begin p = longint'(sa * sb); m_hi = p[63:32]; m_lo = p[31:0]; end
            4'd2: begin p = ua * ub; m_hi = p[63:32]; m_lo = p[31:0]; end
            4'd3: if (b != 0) begin
                q = sa / sb; r = sa % sb;
                m_lo = q[31:0]; m_hi = r[31:0];
            end
            4'd4: if (b != 0) begin
                p = ua / ub; m_lo = p[31:0];
                p = ua % ub; m_hi = p[31:0];
            end
            4'd7: m_hi = a;
            4'd8: m_lo = a;
            default: ;
        endcase
    endtask

    function automatic int latency(input logic [3:0] op);
        if (op == 4'd1 || op == 4'd2) return 5;
        if (op == 4'd3 || op == 4'd4) return 10;
        return 0;
    endfunction

    // Called at the negedge of the first cycle after a start edge.
    task automatic count_busy(output int n);
        n = 0;
        while (Busy === 1'b1 && n < 40) begin
            n++;
            @(negedge clk);
        end
    endtask

    task automatic run_op(input string tag, input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        int n;
        @(negedge clk);
        En = 1'b1; MduOp = op; A = a; B = b;
        @(negedge clk);
        En = 1'b0; MduOp = 4'd0;
        if (latency(op) != 0) begin
            count_busy(n);
            check({tag, "_busy_cycles"}, 64'(n), 64'(latency(op)));
        end else begin
            check({tag, "_no_busy"}, 64'(Busy), 64'd0);
        end
        model_apply(op, a, b);
        check({tag, "_hi"}, 64'(HI), 64'(m_hi));
        check({tag, "_lo"}, 64'(LO), 64'(m_lo));
        $display("op=%0d A=%h B=%h -> HI=%h LO=%h", op, a, b, HI, LO);
    endtask

    task automatic read_check(input string tag);
        MduOp = 4'd5; #1;
        check({tag, "_mfhi"}, 64'(Result), 64'(m_hi));
        MduOp = 4'd6; #1;
        check({tag, "_mflo"}, 64'(Result), 64'(m_lo));
        MduOp = 4'($urandom_range(9, 15)); #1;
        check({tag, "_result_other"}, 64'(Result), 64'd0);
        MduOp = 4'd0;
    endtask

    initial begin
        int n;
        logic [3:0]  op;
        logic [31:0] ra, rb;
        rst_n = 1'b0; En = 1'b0; MduOp = 4'd0; A = '0; B = '0;
        repeat (2) @(negedge clk);
        check("reset_busy", 64'(Busy), 64'd0);
        check("reset_hi", 64'(HI), 64'd0);
        check("reset_lo", 64'(LO), 64'd0);
        rst_n = 1'b1;

        run_op("mult_neg", 4'd1, 32'hFFFF_FFFD, 32'd7);
        check("mult_neg_hi_const", 64'(HI), 64'hFFFF_FFFF);
        check("mult_neg_lo_const", 64'(LO), 64'hFFFF_FFEB);
        run_op("multu", 4'd2, 32'hFFFF_FFFF, 32'd2);
        check("multu_hi_const", 64'(HI), 64'h1);
        read_check("multu");
        run_op("div_neg", 4'd3, 32'hFFFF_FFF9, 32'd2);
        check("div_neg_lo_const", 64'(LO), 64'hFFFF_FFFD);
        check("div_neg_hi_const", 64'(HI), 64'hFFFF_FFFF);
        run_op("div_ovf", 4'd3, 32'h8000_0000, 32'hFFFF_FFFF);
        check("div_ovf_lo_const", 64'(LO), 64'h8000_0000);
        run_op("mthi", 4'd7, 32'h1234_5678, 32'd0);
        run_op("divu_zero", 4'd4, 32'd5, 32'd0);
        check("divu_zero_hi_const", 64'(HI), 64'h1234_5678);

        // Protocol violation: mtlo arriving in the second busy cycle is dropped.
        @(negedge clk);
        En = 1'b1; MduOp = 4'd1; A = 32'd3; B = 32'd4;
        @(negedge clk);
        En = 1'b0; MduOp = 4'd0;
        @(negedge clk);
        En = 1'b1; MduOp = 4'd8; A = 32'h0000_DEAD;
        @(negedge clk);
        En = 1'b0; MduOp = 4'd0;
        count_busy(n);
        check("viol_busy_cycles", 64'(n + 2), 64'd5);
        model_apply(4'd1, 32'd3, 32'd4);
        check("viol_lo", 64'(LO), 64'd12);
        check("viol_hi", 64'(HI), 64'd0);
        $display("violation test: HI=%h LO=%h", HI, LO);

        // Reset in the middle of a run discards the in-flight result.
        @(negedge clk);
        En = 1'b1; MduOp = 4'd1; A = 32'd5; B = 32'd6;
        @(negedge clk);
        En = 1'b0; MduOp = 4'd0;
        @(negedge clk);
        rst_n = 1'b0; #1;
        m_hi = 32'd0; m_lo = 32'd0;
        check("midrst_busy", 64'(Busy), 64'd0);
        check("midrst_hi", 64'(HI), 64'd0);
        check("midrst_lo", 64'(LO), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (8) @(negedge clk);
        check("midrst_late_busy", 64'(Busy), 64'd0);
        check("midrst_late_hi", 64'(HI), 64'd0);
        check("midrst_late_lo", 64'(LO), 64'd0);
        $display("mid-run reset: Busy=%b HI=%h LO=%h", Busy, HI, LO);

        // Randomized stream, including small divisors and divide-by-zero.
        for (int i = 0; i < 60; i++) begin
            op = 4'($urandom_range(1, 8));
            ra = $urandom;
            case ($urandom_range(0, 3))
                0: rb = 32'd0;
                1: rb = 32'($urandom_range(1, 20));
                2: rb = 32'hFFFF_FFFF - 32'($urandom_range(0, 5));
                default: rb = $urandom;
            endcase
            if (op == 4'd5 || op == 4'd6) begin
                @(negedge clk);
                read_check("rand_read");
                $display("read check HI=%h LO=%h", HI, LO);
            end else begin
                run_op("rand", op, ra, rb);
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/mdu_unit.md
# mdu_unit

Multi-cycle multiply/divide unit in the EX stage, beside the ALU. It accepts the same 32-bit operand pair the ALU receives and runs MIPS mult/multu/div/divu into the architectural HI/LO registers. It also services mthi/mtlo/mfhi/mflo. A Busy flag lets the hazard controller stall dependent MDU instructions.

## Interface
- MULT_CYCLES, 5, number of Busy cycles for mult/multu.
- DIV_CYCLES, 10, number of Busy cycles for div/divu.

- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- En  in  1  MDU instruction valid in EX this cycle.
- MduOp  in  4  0 none, 1 mult, 2 multu, 3 div, 4 divu, 5 mfhi, 6 mflo, 7 mthi, 8 mtlo; 9–15 treated as none.
- A  in  32  rs operand.
- B  in  32  rt operand.
- Busy  out  1  registered; high while a mult/div is in flight.
- HI  out  32  architectural HI register.
- LO  out  32  architectural LO register.
- Result  out  32  combinational: HI for op 5, LO for op 6, else 0.

## Operation
- States:
  - IDLE: Busy=0.
  - RUN: Busy=1, down-counter active.
- Transition IDLE→RUN on an edge where En=1 and MduOp is 1–4.
  - At that edge, A/B are captured and the full 64-bit result is computed into pending registers.
  - The counter loads MULT_CYCLES or DIV_CYCLES, matching the op.
- In RUN the counter decrements each edge. When the counter reaches 1, the pending result is written to HI/LO and the state returns to IDLE.
- Arithmetic:
  - mult: {HI,LO} = $signed(A) * $signed(B), 64-bit.
  - multu: {HI,LO} = unsigned 64-bit product.
  - div: LO = quotient truncated toward zero; HI = remainder, which takes the sign of the dividend.
  - divu: unsigned quotient in LO, unsigned remainder in HI.
  - div of 0x80000000 by 0xFFFFFFFF: LO=0x80000000, HI=0.
  - Divide by zero (B=0): the op still runs DIV_CYCLES with Busy=1, but HI/LO stay unchanged at completion.
- mthi/mtlo: with En=1 in IDLE, HI (resp. LO) ← A at the edge. No Busy cycle.
- mfhi/mflo are purely combinational reads of the current HI/LO.
- While in RUN, En=1 with any op 1–4, 7 or 8 is ignored. The controller is required to stall on (Busy | starting op), so this case is a protocol violation. The RTL still must not corrupt state.
- Reset (any time, including mid-operation): state=IDLE, Busy=0, counter=0, HI=0, LO=0, pending registers=0. An in-flight result is discarded.

## Timing
- Start edge T (En=1, op 1–4, in IDLE):
  - Busy=1 during cycles T+1 … T+N, with N = MULT_CYCLES or DIV_CYCLES.
  - HI/LO update at the edge ending cycle T+N.
  - Busy=0 and new HI/LO are visible from cycle T+N+1.
- Back-to-back: a new start is accepted in cycle T+N+1, the first IDLE cycle.
- mthi/mtlo: new value visible the cycle after the write edge.
- Result follows HI/LO and MduOp with zero latency.
- Busy is driven only from a flop; there is no combinational path from En/MduOp to Busy.

## Structure
- Shared package mdu_defs holds:
  - MduOp encodings (MDU_NONE … MDU_MTLO).
  - Default cycle counts.
  - The state enum (MDU_IDLE, MDU_RUN).
- The ALU's AluOp encodings stay in their existing location and are not mixed into mdu_defs.
- Single module. Datapath uses behavioural * and / and %; no iterative divider sub-module is needed. The counter is 4 bits, wide enough for DIV_CYCLES ≤ 15.

## Test plan
- mult, A=0xFFFFFFFD (-3), B=7: Busy high exactly 5 cycles. Then HI=0xFFFFFFFF, LO=0xFFFFFFEB.
- multu, A=0xFFFFFFFF, B=2: HI=0x00000001, LO=0xFFFFFFFE. Then mfhi gives Result=0x00000001 immediately.
- div, A=0xFFFFFFF9 (-7), B=2: Busy high 10 cycles. Then LO=0xFFFFFFFD, HI=0xFFFFFFFF. div 0x80000000 by 0xFFFFFFFF: LO=0x80000000, HI=0.
- mthi A=0x12345678, then divu A=5, B=0: Busy high 10 cycles; HI stays 0x12345678 and LO stays at its prior value.
- Start mult with A=3, B=4. In cycle 2 of Busy, drive En=1, MduOp=mtlo, A=0xDEAD: the mtlo is ignored and LO=12 after completion. Repeat, asserting rst_n=0 mid-run: Busy, HI and LO go to 0 immediately, with no late write after release.
